// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered one-hot grant, hold-time limit and
// back-to-back re-arbitration on release, abort or timeout.
module rr_arbiter #(
    parameter int NUM_ENTRY = 8,
    parameter int MAX_HOLD  = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_ENTRY-1:0] I_Req,
    input  logic                 I_Release,
    output logic [NUM_ENTRY-1:0] O_Grant,
    output logic                 O_Valid,
    output logic                 O_Timeout
);
    localparam int PW = $clog2(NUM_ENTRY);
    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);
    localparam logic [CW-1:0] HOLD_SAT  = CW'(MAX_HOLD);
    localparam logic [PW-1:0] LAST_IDX  = PW'(NUM_ENTRY - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t               state, state_n;
    logic [PW-1:0]        ptr, ptr_n, win, nxt_ptr;
    logic [CW-1:0]        cnt, cnt_n;
    logic [NUM_ENTRY-1:0] grant_n;
    logic                 timeout_n, abort, hit_max;

    // First requester at or after base, wrapping; lowest offset wins.
    function automatic logic [NUM_ENTRY-1:0] rr_pick(input logic [NUM_ENTRY-1:0] req,
                                                     input logic [PW-1:0] base);
        logic [NUM_ENTRY-1:0] g;
        logic [PW-1:0]        idx;
        g = '0;
        for (int i = NUM_ENTRY - 1; i >= 0; i--) begin
            idx = PW'((int'(base) + i) % NUM_ENTRY);
            if (req[idx]) begin
                g      = '0;
                g[idx] = 1'b1;
            end
        end
        return g;
    endfunction

    always_comb begin
        win = '0;
        for (int i = 0; i < NUM_ENTRY; i++)
            if (O_Grant[i]) win = PW'(i);
    end

    assign nxt_ptr = (win == LAST_IDX) ? '0 : win + 1'b1;
    assign abort   = ~|(I_Req & O_Grant);
    assign hit_max = (cnt >= HOLD_LAST);
    assign O_Valid = |O_Grant;

    always_comb begin
        state_n   = state;
        grant_n   = O_Grant;
        ptr_n     = ptr;
        cnt_n     = cnt;
        timeout_n = 1'b0;
        case (state)
            IDLE: begin
                if (|I_Req) begin
                    grant_n = rr_pick(I_Req, ptr);
                    state_n = GRANT;
                    cnt_n   = '0;
                end
            end
            GRANT: begin
                if (I_Release || abort || hit_max) begin
                    ptr_n     = nxt_ptr;
                    // only a pure hold-limit expiry is reported as a timeout
                    timeout_n = hit_max & ~I_Release & ~abort;
                    cnt_n     = '0;
                    if (|I_Req) begin
                        grant_n = rr_pick(I_Req, nxt_ptr);
                    end else begin
                        grant_n = '0;
                        state_n = IDLE;
                    end
                end else if (cnt != HOLD_SAT) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            O_Grant   <= '0;
            O_Timeout <= 1'b0;
            ptr       <= '0;
            cnt       <= '0;
        end else begin
            state     <= state_n;
            O_Grant   <= grant_n;
            O_Timeout <= timeout_n;
            ptr       <= ptr_n;
            cnt       <= cnt_n;
        end
    end
endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: directed scenarios plus random traffic against an
// index/pointer reference model of the arbitration rules.
module tb_rr_arbiter;
    localparam int N  = 8;
    localparam int MH = 16;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] I_Req = '0;
    logic         I_Release = 1'b0;
    logic [N-1:0] O_Grant;
    logic         O_Valid;
    logic         O_Timeout;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model: granted index (-1 = none), priority pointer, cycles held
    int m_idx = -1;
    int m_ptr = 0;
    int m_hold = 0;
    bit m_to = 1'b0;

    rr_arbiter #(.NUM_ENTRY(N), .MAX_HOLD(MH)) dut (
        .clock(clock), .reset(reset), .I_Req(I_Req), .I_Release(I_Release),
        .O_Grant(O_Grant), .O_Valid(O_Valid), .O_Timeout(O_Timeout)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int first_req(input logic [N-1:0] req, input int base);
        for (int k = 0; k < N; k++)
            if (req[(base + k) % N]) return (base + k) % N;
        return -1;
    endfunction

    task automatic m_reset();
        m_idx = -1; m_ptr = 0; m_hold = 0; m_to = 1'b0;
    endtask

    task automatic m_tick(input logic [N-1:0] req, input bit rel);
        bit ab, tmo;
        if (m_idx < 0) begin
            m_to = 1'b0;
            if (req != '0) begin
                m_idx  = first_req(req, m_ptr);
                m_hold = 0;
            end
        end else begin
            ab  = !req[m_idx];
            tmo = (m_hold == MH - 1);
            if (rel || ab || tmo) begin
                m_to   = tmo && !rel && !ab;
                m_ptr  = (m_idx + 1) % N;
                m_idx  = first_req(req, m_ptr);
                m_hold = 0;
            end else begin
                m_to = 1'b0;
                m_hold++;
            end
        end
    endtask

    function automatic logic [N-1:0] m_grant();
        logic [N-1:0] g;
        g = '0;
        if (m_idx >= 0) g[m_idx] = 1'b1;
        return g;
    endfunction

    task automatic check_outs();
        chk("grant", O_Grant, m_grant());
        chk("valid", O_Valid, m_idx >= 0);
        chk("timeout", O_Timeout, m_to);
        chk("onehot0", $onehot0(O_Grant), 1);
        chk("valid_or", O_Valid, |O_Grant);
    endtask

    // drive inputs, take one clock edge, advance model, check #1 after the edge
    task automatic step(input logic [N-1:0] req, input bit rel);
        I_Req = req;
        I_Release = rel;
        @(posedge clock);
        m_tick(req, rel);
        #1;
        check_outs();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        m_reset();
        chk("rst_grant", O_Grant, 0);
        chk("rst_valid", O_Valid, 0);
        chk("rst_timeout", O_Timeout, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        logic [N-1:0] r;
        bit rl;
        #2;
        do_reset();

        // basic rotation with wrap
        step(8'hA4, 0); chk("s1_g0", O_Grant, 8'h04); chk("s1_v0", O_Valid, 1);
        step(8'hA4, 1); chk("s1_g1", O_Grant, 8'h20);
        step(8'hA4, 1); chk("s1_g2", O_Grant, 8'h80);
        step(8'hA4, 1); chk("s1_g3", O_Grant, 8'h04);
        step(8'hA4, 0); chk("s1_rel_idle_hold", O_Grant, 8'h04);

        // all requesting, release every third cycle
        do_reset();
        for (int c = 0; c < 30; c++) step(8'hFF, (c % 3) == 2);

        // hold-limit timeout on index 3, pointer moves to 4
        do_reset();
        step(8'h08, 0);
        for (int c = 0; c < MH - 1; c++) step(8'h08, 0);
        chk("s3_pre", O_Timeout, 0);
        step(8'h18, 0); chk("s3_g", O_Grant, 8'h10); chk("s3_to", O_Timeout, 1);
        step(8'h18, 1); chk("s3_to_end", O_Timeout, 0);

        // release coinciding with hold limit is a normal release
        do_reset();
        step(8'h08, 0);
        for (int c = 0; c < MH - 1; c++) step(8'h08, 0);
        step(8'h08, 1); chk("s4_to", O_Timeout, 0); chk("s4_regrant", O_Grant, 8'h08);

        // abort: drop granted bit, another requester picked up next cycle
        do_reset();
        step(8'h20, 0); chk("s5_g", O_Grant, 8'h20);
        step(8'h22, 0); chk("s5_hold", O_Grant, 8'h20);
        step(8'h02, 0); chk("s5_abort", O_Grant, 8'h02); chk("s5_to", O_Timeout, 0);

        // idle release ignored
        do_reset();
        step(8'h00, 1); chk("s6_idle", O_Valid, 0);

        // asynchronous reset in the middle of a grant
        step(8'h40, 0);
        #3;
        reset = 1'b1;
        #1;
        chk("s7_async_g", O_Grant, 0);
        chk("s7_async_v", O_Valid, 0);
        m_reset();
        @(negedge clock);
        reset = 1'b0;
        step(8'h81, 0); chk("s7_after", O_Grant, 8'h01);

        // random traffic, mostly stable requests so holds can time out
        r = 8'h00;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) < 1) begin
                #2;
                do_reset();
            end
            case ($urandom_range(0, 9))
                0: r = $urandom;
                1: r = $urandom & $urandom;
                2: r = r ^ (8'h01 << $urandom_range(0, N - 1));
                default: ;
            endcase
            rl = ($urandom_range(0, 11) == 0);
            step(r, rl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_ENTRY, default 8, the number of requesters; NUM_ENTRY SHALL be >= 2.
REQ-002 The block SHALL have parameter MAX_HOLD, default 16, the maximum number of cycles one grant is held before forced release.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port I_Req, input, NUM_ENTRY bits: request vector, one bit per requester.
REQ-007 The block SHALL have port I_Release, input, 1 bit: single-cycle release of the current grant.
REQ-008 The block SHALL have port O_Grant, output, NUM_ENTRY bits: registered grant, one-hot or zero; this feeds the downstream one-hot-to-binary encoder.
REQ-009 The block SHALL have port O_Valid, output, 1 bit: a grant is held, equal to |O_Grant.
REQ-010 The block SHALL have port O_Timeout, output, 1 bit: one-cycle pulse on forced release.

Function
REQ-011 The block SHALL have two states. IDLE: no grant. GRANT: one grant held.
REQ-012 O_Grant SHALL never have more than one bit set; this is the one-hot guarantee the downstream encoder relies on.
REQ-013 The block SHALL hold a pointer Ptr, width $clog2(NUM_ENTRY), giving the highest-priority index.
- Priority search order: Ptr, Ptr+1, ..., NUM_ENTRY-1, 0, ..., Ptr-1.
REQ-014 In IDLE with I_Req != 0 at edge t, the block SHALL do all of the following at edge t:
- set O_Grant to the one-hot of the first requesting index in the search order;
- go to GRANT;
- clear the hold counter.
Result: a grant appears one cycle after the request.
REQ-015 In IDLE with I_Req == 0, the state, O_Grant and Ptr SHALL be unchanged.
REQ-016 In GRANT, O_Grant SHALL stay constant until one of these release conditions occurs:
- I_Release == 1;
- the granted I_Req bit drops to 0 (abort);
- the hold counter reaches MAX_HOLD-1 (timeout).
REQ-017 On any release condition, the block SHALL set Ptr to (winner+1) mod NUM_ENTRY, so that winner NUM_ENTRY-1 wraps to 0.
REQ-018 On release, in the same edge, the block SHALL re-arbitrate I_Req using the updated Ptr.
- If any request remains, the block SHALL grant it back-to-back with no idle cycle and stay in GRANT.
- Otherwise it SHALL clear O_Grant and go to IDLE.
REQ-019 A sole requester that keeps its request high through release SHALL be re-granted on the next cycle.
REQ-020 The hold counter SHALL increment each cycle in GRANT and SHALL clear on every new grant.
- The counter width SHALL be $clog2(MAX_HOLD+1).
- The counter SHALL saturate and never wrap.
REQ-021 O_Timeout SHALL be registered and SHALL pulse for exactly the one cycle after a timeout release.
- Abort and I_Release SHALL NOT raise O_Timeout.
REQ-022 If I_Release and timeout occur in the same cycle, the event SHALL be treated as a normal release with O_Timeout=0.
REQ-023 I_Release asserted in IDLE SHALL be ignored.
REQ-024 Changes to I_Req while in GRANT SHALL NOT alter O_Grant except through the abort condition of REQ-016.

Reset
REQ-025 While reset=1, the block SHALL asynchronously force all of the following:
- state = IDLE;
- O_Grant = 0, O_Valid = 0, O_Timeout = 0;
- Ptr = 0;
- hold counter = 0.
REQ-026 Reset asserted in the middle of a grant SHALL drop the grant immediately without waiting for a clock edge.
REQ-027 After reset deasserts, the first arbitration SHALL favour index 0.

Verification
REQ-028 Reset, then I_Req=8'b1010_0100 -> one cycle later O_Grant=8'b0000_0100 and O_Valid=1; after I_Release, next grant 8'b0010_0000, then 8'b1000_0000, then 8'b0000_0100 (wrap).
REQ-029 I_Req=8'hFF held with I_Release pulsed every 3 cycles -> grants cycle through indices 0..7 then 0 with no idle cycle between grants, and O_Grant is always one-hot.
REQ-030 Grant index 3 with no I_Release for 16 cycles -> forced release after cycle 16, O_Timeout=1 for one cycle, Ptr=4.
REQ-031 Grant index 5, then drop I_Req[5] with I_Req[1]=1 -> next cycle O_Grant=8'b0000_0010 and O_Timeout=0.
REQ-032 Reset asserted mid-grant between clock edges -> O_Grant=0 immediately; after reset releases with I_Req=8'h81, O_Grant=8'h01.
REQ-033 On every cycle of every scenario, a checker SHALL assert $onehot0(O_Grant) and O_Valid == |O_Grant.
